// File: rtl/sha256_pkg.sv
// Shared SHA-256 widths, round bounds, initial hash value and the iterative engine's FSM encoding.
package sha256_pkg;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 512;
    localparam int STATE_W         = 256;
    localparam int ROUND_W         = 6;
    localparam int ROUND_FIRST_DEF = 16;
    localparam int ROUND_LAST_DEF  = 63;

    localparam logic [STATE_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Word-wise add of two 8-word states, carries never cross word boundaries.
    function automatic logic [STATE_W-1:0] state_add(input logic [STATE_W-1:0] a,
                                                     input logic [STATE_W-1:0] b);
        logic [STATE_W-1:0] r;
        r = '0;
        for (int j = 0; j < STATE_W / WORD_W; j++)
            r[j*WORD_W +: WORD_W] = a[j*WORD_W +: WORD_W] + b[j*WORD_W +: WORD_W];
        return r;
    endfunction
endpackage

// File: rtl/sha256_k_lookup.sv
// SHA-256 round constant K[t] lookup, purely combinational.
module sha256_k_lookup
    import sha256_pkg::*;
(
    input  logic [ROUND_W-1:0] i_round,
    output logic [WORD_W-1:0]  o_k
);
    localparam logic [WORD_W-1:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    assign o_k = K_ROM[i_round];
endmodule

// File: rtl/sha256_round_fn.sv
// One SHA-256 compression round: working state a..h (a in the top word) plus K[t], W[t] -> next state.
module sha256_round_fn
    import sha256_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [WORD_W-1:0]  i_k,
    input  logic [WORD_W-1:0]  i_w,
    output logic [STATE_W-1:0] o_state
);
    logic [WORD_W-1:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [WORD_W-1:0] w_bsig0, w_bsig1, w_ch, w_maj, w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    assign w_bsig0 = rotr(w_a, 2) ^ rotr(w_a, 13) ^ rotr(w_a, 22);
    assign w_bsig1 = rotr(w_e, 6) ^ rotr(w_e, 11) ^ rotr(w_e, 25);
    assign w_ch    = (w_e & w_f) ^ (~w_e & w_g);
    assign w_maj   = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
    assign w_t1    = w_h + w_bsig1 + w_ch + i_k + i_w;
    assign w_t2    = w_bsig0 + w_maj;

    assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
endmodule

// File: rtl/sha256_schedule_w.sv
// Message schedule expansion: W[t] from the 16-word window (w0 = W[t-16] ... w15 = W[t-1]).
module sha256_schedule_w
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_w0,
    input  logic [WORD_W-1:0] i_w1,
    input  logic [WORD_W-1:0] i_w9,
    input  logic [WORD_W-1:0] i_w14,
    output logic [WORD_W-1:0] o_wt
);
    logic [WORD_W-1:0] w_sig0, w_sig1;

    assign w_sig0 = rotr(i_w1, 7) ^ rotr(i_w1, 18) ^ (i_w1 >> 3);
    assign w_sig1 = rotr(i_w14, 17) ^ rotr(i_w14, 19) ^ (i_w14 >> 10);
    assign o_wt   = w_sig1 + i_w9 + w_sig0 + i_w0;
endmodule

// File: rtl/sha256_round_back_iter.sv
// Iterative SHA-256 rounds 16..63, one round per clk; SHA256_BACK_FINAL_ADD_EN adds the chaining value to the digest.
//   state   | meaning
//   ST_IDLE | waiting for a block from the front stage (in_ready=1)
//   ST_RUN  | one round per cycle, cnt = round being computed
//   ST_DONE | digest_out held with out_valid=1 until out_ready
module sha256_round_back_iter
    import sha256_pkg::*;
#(
    parameter int ROUND_FIRST = ROUND_FIRST_DEF,
    parameter int ROUND_LAST  = ROUND_LAST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ROUND_W-1:0] round_in,
    input  logic [BLOCK_W-1:0] block_in,
    input  logic [STATE_W-1:0] hash_middle_in,
    input  logic [STATE_W-1:0] hash_init_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] digest_out,
    output logic               round_err
);
    fsm_e               r_fsm;
    logic [ROUND_W-1:0] r_cnt;
    logic [WORD_W-1:0]  r_win [16];
    logic [STATE_W-1:0] r_work;
    logic [STATE_W-1:0] r_digest;
    logic               r_out_valid;
    logic               r_round_err;

    logic [WORD_W-1:0]  w_k;
    logic [WORD_W-1:0]  w_wt;
    logic [STATE_W-1:0] w_work_next;
    logic [STATE_W-1:0] w_digest_next;
    logic               w_accept;

    assign w_accept   = in_valid && (r_fsm == ST_IDLE);
    assign in_ready   = (r_fsm == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign digest_out = r_digest;
    assign round_err  = r_round_err;

    sha256_k_lookup u_k (
        .i_round (r_cnt),
        .o_k     (w_k)
    );

    sha256_schedule_w u_sched (
        .i_w0  (r_win[0]),
        .i_w1  (r_win[1]),
        .i_w9  (r_win[9]),
        .i_w14 (r_win[14]),
        .o_wt  (w_wt)
    );

    sha256_round_fn u_round (
        .i_state (r_work),
        .i_k     (w_k),
        .i_w     (w_wt),
        .o_state (w_work_next)
    );

`ifdef SHA256_BACK_FINAL_ADD_EN
    logic [STATE_W-1:0] r_init;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_init <= '0;
        else if (w_accept)
            r_init <= hash_init_in;
    end

    assign w_digest_next = state_add(w_work_next, r_init);
`else
    // Chaining value is not needed without the final add; fold it away.
    logic w_unused_init;
    assign w_unused_init = ^hash_init_in;
    assign w_digest_next = w_work_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= ST_IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_digest    <= '0;
            r_out_valid <= 1'b0;
            r_round_err <= 1'b0;
            for (int i = 0; i < 16; i++)
                r_win[i] <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i < 16; i++)
                            r_win[i] <= block_in[BLOCK_W-1-WORD_W*i -: WORD_W];
                        r_work <= hash_middle_in;
                        r_cnt  <= ROUND_W'(ROUND_FIRST);
                        // Out-of-sequence round index is flagged but the block is still processed from ROUND_FIRST.
                        if (round_in != ROUND_W'(ROUND_FIRST))
                            r_round_err <= 1'b1;
                        r_fsm <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < 15; i++)
                        r_win[i] <= r_win[i+1];
                    r_win[15] <= w_wt;
                    r_work    <= w_work_next;
                    if (r_cnt == ROUND_W'(ROUND_LAST)) begin
                        r_digest    <= w_digest_next;
                        r_out_valid <= 1'b1;
                        r_fsm       <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + ROUND_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_round_back_iter.sv
// Directed-vector bench for sha256_round_back_iter; expectations from known SHA-256 digests and a reference compression model.
`timescale 1ns/1ps
module tb_sha256_round_back_iter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [5:0]   round_in = '0;
    logic [511:0] block_in = '0;
    logic [255:0] hash_middle_in = '0;
    logic [255:0] hash_init_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] digest_out;
    logic         round_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sha256_round_back_iter dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .round_in       (round_in),
        .block_in       (block_in),
        .hash_middle_in (hash_middle_in),
        .hash_init_in   (hash_init_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .digest_out     (digest_out),
        .round_err      (round_err)
    );

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] B1_BLK = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2_BLK = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] CHAIN_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    typedef struct {
        logic [511:0] blk;
        logic [5:0]   rnd;
        logic [255:0] hinit;
        logic [255:0] exp_full;
    } vec_t;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression: working state after the first n rounds, no final add.
    function automatic logic [255:0] rounds(input logic [511:0] blk, input logic [255:0] h, input int n);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < n; t++) begin
            t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[t] + w[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a, b, c, d, e, f, g, hh};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = x[32*j +: 32] + y[32*j +: 32];
        return r;
    endfunction

    function automatic logic [255:0] sub8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = x[32*j +: 32] - y[32*j +: 32];
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom();
        return r;
    endfunction

    // Digest the DUT should emit for a block whose full SHA-256 compression result is 'full'.
    function automatic logic [255:0] exp_dut(input logic [255:0] full, input logic [255:0] hinit);
`ifdef SHA256_BACK_FINAL_ADD_EN
        return full;
`else
        return sub8(full, hinit);
`endif
    endfunction

    // Chaining value recovered from a DUT digest.
    function automatic logic [255:0] to_full(input logic [255:0] dig, input logic [255:0] hinit);
`ifdef SHA256_BACK_FINAL_ADD_EN
        return dig;
`else
        return add8(dig, hinit);
`endif
    endfunction

    function automatic logic [255:0] drive_init(input logic [255:0] hinit);
`ifdef SHA256_BACK_FINAL_ADD_EN
        return hinit;
`else
        return rand256();
`endif
    endfunction

    task automatic check_v(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer one block, return the digest and the number of edges from accept to out_valid.
    task automatic run_block(input logic [511:0] blk, input logic [5:0] rnd, input logic [255:0] hinit,
                             output logic [255:0] dig, output int lat);
        @(negedge clk);
        block_in       = blk;
        round_in       = rnd;
        hash_middle_in = rounds(blk, hinit, 16);
        hash_init_in   = drive_init(hinit);
        in_valid       = 1'b1;
        check_b("in_ready_idle", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid       = 1'b0;
        hash_init_in   = rand256();
        hash_middle_in = rand256();
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        dig = digest_out;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [4];
        logic [511:0] rblk;
        logic [255:0] rinit, dig, h1;
        int           lat;
        logic         stable, saw_valid;

        for (int i = 0; i < 16; i++) rblk[511-32*i -: 32] = $urandom();
        rinit = rand256();
        vecs[0] = '{blk: ABC_BLK,   rnd: 6'd16, hinit: IV, exp_full: ABC_DIG};
        vecs[1] = '{blk: EMPTY_BLK, rnd: 6'd16, hinit: IV, exp_full: EMPTY_DIG};
        vecs[2] = '{blk: rblk,      rnd: 6'd16, hinit: IV, exp_full: add8(rounds(rblk, IV, 64), IV)};
        vecs[3] = '{blk: ~rblk,     rnd: 6'd16, hinit: rinit, exp_full: add8(rounds(~rblk, rinit, 64), rinit)};

        // Reset state
        repeat (2) @(negedge clk);
        check_b("rst_out_valid", out_valid, 1'b0);
        check_v("rst_digest", digest_out, '0);
        check_b("rst_round_err", round_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_b("rst_in_ready", in_ready, 1'b1);

        for (int v = 0; v < 4; v++) begin
            run_block(vecs[v].blk, vecs[v].rnd, vecs[v].hinit, dig, lat);
            check_i($sformatf("vec%0d_latency", v), lat, 48);
            check_v($sformatf("vec%0d_digest", v), dig, exp_dut(vecs[v].exp_full, vecs[v].hinit));
            check_b($sformatf("vec%0d_in_ready_done", v), in_ready, 1'b0);
            check_b($sformatf("vec%0d_round_err", v), round_err, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check_b($sformatf("vec%0d_out_valid_clr", v), out_valid, 1'b0);
            check_b($sformatf("vec%0d_in_ready_back", v), in_ready, 1'b1);
        end

        // Backpressure in DONE with a second block offered
        out_ready = 1'b0;
        run_block(ABC_BLK, 6'd16, IV, dig, lat);
        check_i("bp_latency", lat, 48);
        block_in = EMPTY_BLK;
        hash_middle_in = rounds(EMPTY_BLK, IV, 16);
        in_valid = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (digest_out !== dig || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check_b("bp_hold_stable", stable, 1'b1);
        check_v("bp_digest", digest_out, exp_dut(ABC_DIG, IV));
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_b("bp_release_out_valid", out_valid, 1'b0);
        saw_valid = 1'b0;
        repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check_b("bp_no_second_accept", saw_valid, 1'b0);

        // Wrong round index on accept
        run_block(ABC_BLK, 6'd5, IV, dig, lat);
        check_b("rerr_set", round_err, 1'b1);
        check_v("rerr_digest", dig, exp_dut(ABC_DIG, IV));
        @(posedge clk);
        run_block(EMPTY_BLK, 6'd16, IV, dig, lat);
        check_v("rerr_next_digest", dig, exp_dut(EMPTY_DIG, IV));
        check_b("rerr_sticky", round_err, 1'b1);
        @(posedge clk);

        // Reset pulse during RUN
        @(negedge clk);
        block_in = ABC_BLK;
        round_in = 6'd16;
        hash_middle_in = rounds(ABC_BLK, IV, 16);
        hash_init_in = drive_init(IV);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_b("midrst_out_valid", out_valid, 1'b0);
        check_v("midrst_digest", digest_out, '0);
        check_b("midrst_round_err", round_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check_b("midrst_nothing_emitted", saw_valid, 1'b0);
        check_b("midrst_in_ready", in_ready, 1'b1);
        run_block(ABC_BLK, 6'd16, IV, dig, lat);
        check_i("midrst_latency", lat, 48);
        check_v("midrst_digest_after", dig, exp_dut(ABC_DIG, IV));
        @(posedge clk);

        // Two-block message, chained
        run_block(B1_BLK, 6'd16, IV, dig, lat);
        h1 = to_full(dig, IV);
        check_v("chain_h1", h1, add8(rounds(B1_BLK, IV, 64), IV));
        run_block(B2_BLK, 6'd16, h1, dig, lat);
        check_i("chain_latency", lat, 48);
        check_v("chain_digest", to_full(dig, h1), CHAIN_DIG);
        @(posedge clk);
        @(negedge clk);
        check_b("chain_out_valid_clr", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
